// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, state encoding and round helper functions
package sha256_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, HOLD} state_t;
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] sum0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] sum1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction
endpackage

// File: rtl/sha256_round_engine_if.sv
// sha256_round_engine_if: block input handshake (valid/ready, 512-bit block, 256-bit initial state)
interface sha256_round_engine_if;
  logic         block_valid;
  logic         block_ready;
  logic [511:0] block_in;
  logic [255:0] init_state;
  modport master (output block_valid, block_in, init_state, input block_ready);
  modport slave (input block_valid, block_in, init_state, output block_ready);
endinterface

// File: rtl/sha256_msg_window.sv
// sha256_msg_window: 16-word message schedule shift register presenting W_t on w0_o
module sha256_msg_window
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [511:0] block_i,
  output logic [31:0]  w0_o
);
  logic [0:15][31:0] w_q;
  logic [31:0] w_new;
  assign w_new = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];
  assign w0_o = w_q[0];
  always_ff @(posedge clk) begin
    if (rst) w_q <= '0;
    else if (load_i) w_q <= block_i;
    else if (shift_i) w_q <= {w_q[1:15], w_new};
  end
endmodule

// File: rtl/sha256_round_engine.sv
// sha256_round_engine: 64-round SHA-256 compression, one round per clock, result held HOLD_CYCLES cycles
module sha256_round_engine
  import sha256_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  sha256_round_engine_if.slave        blk,
  output logic [6:0]                  counter_iteration_o,
  output logic [31:0]                 a_out_o,
  output logic [31:0]                 b_out_o,
  output logic [31:0]                 c_out_o,
  output logic [31:0]                 d_out_o,
  output logic [31:0]                 e_out_o,
  output logic [31:0]                 f_out_o,
  output logic [31:0]                 g_out_o,
  output logic [31:0]                 h_out_o,
  output logic                        round_done_o
);
  state_t state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [3:0] hc_q, hc_d;
  logic [7:0][31:0] s_q, s_d;
  logic load, shift, last;
  logic [31:0] w0, t1, t2;
  sha256_msg_window u_win (
    .clk(clk),
    .rst(rst),
    .load_i(load),
    .shift_i(shift),
    .block_i(blk.block_in),
    .w0_o(w0)
  );
  assign t1 = s_q[0] + sum1(s_q[3]) + ch(s_q[3], s_q[2], s_q[1]) + K[cnt_q[5:0]] + w0;
  assign t2 = sum0(s_q[7]) + maj(s_q[7], s_q[6], s_q[5]);
  assign last = hc_q == 4'(HOLD_CYCLES - 1);
  assign blk.block_ready = state_q == IDLE;
  assign round_done_o = state_q == HOLD && hc_q == '0;
  assign counter_iteration_o = cnt_q;
  assign {a_out_o, b_out_o, c_out_o, d_out_o, e_out_o, f_out_o, g_out_o, h_out_o} = s_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hc_d = hc_q;
    s_d = s_q;
    load = 1'b0;
    shift = 1'b0;
    case (state_q)
      IDLE: begin
        load = blk.block_valid;
        state_d = blk.block_valid ? ROUND : IDLE;
        s_d = blk.block_valid ? blk.init_state : s_q;
        cnt_d = '0;
      end
      ROUND: begin
        shift = 1'b1;
        cnt_d = cnt_q + 7'd1;
        s_d = {t1 + t2, s_q[7:5], s_q[4] + t1, s_q[3:1]};
        state_d = cnt_q == 7'd63 ? HOLD : ROUND;
        hc_d = '0;
      end
      HOLD: begin
        state_d = last ? IDLE : HOLD;
        cnt_d = last ? '0 : cnt_q;
        hc_d = hc_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hc_q <= '0;
      s_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hc_q <= hc_d;
      s_q <= s_d;
    end
  end
endmodule

// File: tb/tb_sha256_round_engine.sv
// tb_sha256_round_engine: directed checks of the round engine against hand values and a reference model
module tb_sha256_round_engine;
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_FIN = {32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
                                      32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894};
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] c0, c1;
  logic [31:0] o0 [8];
  logic [31:0] o1 [8];
  logic d0, d1;
  int n_cmp = 0;
  int n_err = 0;
  sha256_round_engine_if bus0 ();
  sha256_round_engine_if bus1 ();
  sha256_round_engine #(.HOLD_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .blk(bus0), .counter_iteration_o(c0),
    .a_out_o(o0[0]), .b_out_o(o0[1]), .c_out_o(o0[2]), .d_out_o(o0[3]),
    .e_out_o(o0[4]), .f_out_o(o0[5]), .g_out_o(o0[6]), .h_out_o(o0[7]), .round_done_o(d0)
  );
  sha256_round_engine #(.HOLD_CYCLES(3)) u1 (
    .clk(clk), .rst(rst), .blk(bus1), .counter_iteration_o(c1),
    .a_out_o(o1[0]), .b_out_o(o1[1]), .c_out_o(o1[2]), .d_out_o(o1[3]),
    .e_out_o(o1[4]), .f_out_o(o1[5]), .g_out_o(o1[6]), .h_out_o(o1[7]), .round_done_o(d1)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [255:0] ref_compress(input logic [511:0] m, input logic [255:0] st);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32 * i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = st[255 - 32 * i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
  endfunction
  task automatic run0(input logic [511:0] b, input logic [255:0] s, input bit busy,
                      output logic [255:0] st1, output logic [255:0] fin,
                      output int lat, output int n64, output int nd);
    lat = 0; n64 = 0; nd = 0; fin = '0; st1 = '0;
    @(negedge clk);
    bus0.block_valid = 1'b1; bus0.block_in = b; bus0.init_state = s;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 2) st1 = {o0[0], o0[1], o0[2], o0[3], o0[4], o0[5], o0[6], o0[7]};
      if (c0 == 7'd64) begin
        n64++;
        if (lat == 0) begin
          lat = i;
          fin = {o0[0], o0[1], o0[2], o0[3], o0[4], o0[5], o0[6], o0[7]};
        end
      end
      if (d0) nd++;
      if (i == 1) begin
        bus0.block_valid = busy;
        bus0.block_in = {16{32'hdeadbeef}};
        bus0.init_state = '0;
      end
      if (i == 60) bus0.block_valid = 1'b0;
    end
  endtask
  initial begin
    logic [255:0] st1, fin, fin1a, fin1b;
    int lat, n64, nd, f, j2, nacc, n64a, n64b, nd1;
    bit drop;
    bus0.block_valid = 1'b0; bus0.block_in = '0; bus0.init_state = '0;
    bus1.block_valid = 1'b0; bus1.block_in = '0; bus1.init_state = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_counter", 256'(c0), 256'd0);
    chk("rst_a", 256'(o0[0]), 256'd0);
    chk("rst_h", 256'(o0[7]), 256'd0);
    chk("rst_done", 256'(d0), 256'd0);
    chk("rst_ready", 256'(bus0.block_ready), 256'd1);
    run0(ABC, IV, 1'b0, st1, fin, lat, n64, nd);
    chk("r0_a", 256'(st1[255:224]), 256'(32'h5d6aebcd));
    chk("r0_e", 256'(st1[127:96]), 256'(32'hfa2a4622));
    for (int k = 0; k < 8; k++) chk($sformatf("abc_w%0d", k), 256'(fin[255 - 32 * k -: 32]), 256'(ABC_FIN[255 - 32 * k -: 32]));
    chk("abc_latency", 256'(lat), 256'd65);
    chk("abc_cnt64_cycles", 256'(n64), 256'd1);
    chk("abc_done_cycles", 256'(nd), 256'd1);
    chk("idle_ready", 256'(bus0.block_ready), 256'd1);
    chk("idle_counter", 256'(c0), 256'd0);
    chk("idle_keep_a", 256'(o0[0]), 256'(32'h506e3058));
    @(negedge clk);
    bus0.block_valid = 1'b1; bus0.block_in = ABC; bus0.init_state = IV;
    @(negedge clk);
    bus0.block_valid = 1'b0;
    chk("busy_ready", 256'(bus0.block_ready), 256'd0);
    for (int i = 0; i < 100 && c0 != 7'd30; i++) @(negedge clk);
    chk("reach30", 256'(c0), 256'd30);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_counter", 256'(c0), 256'd0);
    chk("mid_rst_ready", 256'(bus0.block_ready), 256'd1);
    chk("mid_rst_a", 256'(o0[0]), 256'd0);
    rst = 1'b0;
    nd = 0; n64 = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (d0) nd++;
      if (c0 == 7'd64) n64++;
    end
    chk("mid_rst_no_done", 256'(nd), 256'd0);
    chk("mid_rst_no_64", 256'(n64), 256'd0);
    run0(ABC, IV, 1'b0, st1, fin, lat, n64, nd);
    chk("resend_abc", fin, ABC_FIN);
    run0(ABC, IV, 1'b1, st1, fin, lat, n64, nd);
    chk("busy_ignored_abc", fin, ABC_FIN);
    chk("busy_latency", 256'(lat), 256'd65);
    run0('0, '1, 1'b0, st1, fin, lat, n64, nd);
    chk("maxval_model", fin, ref_compress('0, '1));
    f = -1; j2 = -1; nacc = 0; n64a = 0; n64b = 0; nd1 = 0; drop = 1'b0;
    fin1a = '0; fin1b = '0;
    @(negedge clk);
    bus1.block_valid = 1'b1; bus1.block_in = ABC; bus1.init_state = IV;
    if (bus1.block_ready) nacc = 1;
    for (int j = 1; j <= 250; j++) begin
      @(negedge clk);
      if (drop) bus1.block_valid = 1'b0;
      if (c1 == 7'd64) begin
        if (j2 < 0) begin
          n64a++;
          if (f < 0) begin
            f = j;
            fin1a = {o1[0], o1[1], o1[2], o1[3], o1[4], o1[5], o1[6], o1[7]};
          end
        end else begin
          n64b++;
          fin1b = {o1[0], o1[1], o1[2], o1[3], o1[4], o1[5], o1[6], o1[7]};
        end
      end
      if (d1) nd1++;
      if (j == 1) begin
        bus1.block_in = '0;
        bus1.init_state = '1;
      end
      if (bus1.block_valid && bus1.block_ready) begin
        nacc++;
        if (nacc == 2) begin
          j2 = j;
          drop = 1'b1;
        end
      end
    end
    chk("b2b_accepts", 256'(nacc), 256'd2);
    chk("b2b_first64", 256'(f), 256'd65);
    chk("b2b_hold1", 256'(n64a), 256'd3);
    chk("b2b_hold2", 256'(n64b), 256'd3);
    chk("b2b_gap", 256'(j2 - f), 256'd3);
    chk("b2b_done_pulses", 256'(nd1), 256'd2);
    chk("b2b_fin1", fin1a, ABC_FIN);
    chk("b2b_fin2", fin1b, ref_compress('0, '1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
